// File: rtl/exec_sequencer_if.sv
// Instruction-memory read channel between the sequencer and its memory.
//   imem_req   : read request (sequencer -> memory)
//   imem_addr  : read address, valid while imem_req is high
//   imem_ack   : read data valid (memory -> sequencer)
//   imem_rdata : 32-bit instruction word qualified by imem_ack
interface exec_sequencer_if #(
    parameter int unsigned PC_WIDTH = 16
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/exec_sequencer.sv
// Instruction fetch/execute sequencer: HALT -> FETCH -> WAIT -> EXEC loop,
// with a sticky STOP entered on the halt opcode (instr0[31:24] == 8'hFF).
//   clk, reset    : clock and asynchronous active-high reset
//   run           : level enabling the sequencer to leave HALT / keep fetching
//   imem          : instruction-memory read channel (master side)
//   instr0        : latched current instruction
//   current_state : HALT=0, FETCH=1, WAIT=2, EXEC=3, STOP=4
//   pc            : address of the next instruction to fetch
//   retired       : count of instructions that completed EXEC
//   halted        : high in HALT and STOP
module exec_sequencer #(
    parameter int unsigned         PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    exec_sequencer_if.master       imem,
    output logic [31:0]            instr0,
    output logic [3:0]             current_state,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [31:0]            retired,
    output logic                   halted
);
    localparam int unsigned RET_W   = 32;
    localparam logic [7:0]  HALT_OP = 8'hFF;

    typedef enum logic [3:0] {
        HALT  = 4'd0,
        FETCH = 4'd1,
        WAIT  = 4'd2,
        EXEC  = 4'd3,
        STOP  = 4'd4
    } state_t;

    state_t state;

    // State code straight from the state register.
    assign current_state = state;

    // Sequencer FSM; request/address/halted are updated together with the
    // state so that they are registered and carry no input-to-output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= HALT;
            pc             <= RESET_PC;
            instr0         <= '0;
            retired        <= '0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            halted         <= 1'b1;
        end else begin
            case (state)
                HALT: begin
                    if (run) begin
                        state          <= FETCH;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc;
                        halted         <= 1'b0;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Wait indefinitely for the memory to acknowledge.
                    if (imem.imem_ack) begin
                        instr0         <= imem.imem_rdata;
                        pc             <= pc + PC_WIDTH'(1);
                        state          <= EXEC;
                        imem.imem_req  <= 1'b0;
                        imem.imem_addr <= '0;
                    end
                end
                EXEC: begin
                    retired <= retired + RET_W'(1);
                    // Halt opcode has priority over a dropped run level.
                    if (instr0[31:24] == HALT_OP) begin
                        state  <= STOP;
                        halted <= 1'b1;
                    end else if (!run) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state          <= FETCH;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc;
                    end
                end
                STOP: begin
                    state <= STOP;
                end
                default: begin
                    state          <= HALT;
                    imem.imem_req  <= 1'b0;
                    imem.imem_addr <= '0;
                    halted         <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: per-cycle expected traces are built
// per instruction (fetch, wait latency, execute, follow-on) and replayed.
module tb_exec_sequencer;
    localparam logic [3:0] S_HALT  = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_EXEC  = 4'd3;
    localparam logic [3:0] S_STOP  = 4'd4;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] instr0;
    logic [3:0]  current_state;
    logic [15:0] pc;
    logic [31:0] retired;
    logic        halted;

    logic        run2;
    logic [31:0] instr0_2;
    logic [3:0]  state_2;
    logic [3:0]  pc_2;
    logic [31:0] retired_2;
    logic        halted_2;

    exec_sequencer_if #(.PC_WIDTH(16)) bus ();
    exec_sequencer_if #(.PC_WIDTH(4))  bus2 ();

    exec_sequencer #(.PC_WIDTH(16), .RESET_PC(16'd0)) dut (
        .clk(clk), .reset(reset), .run(run), .imem(bus.master),
        .instr0(instr0), .current_state(current_state), .pc(pc),
        .retired(retired), .halted(halted)
    );

    exec_sequencer #(.PC_WIDTH(4), .RESET_PC(4'd15)) dut2 (
        .clk(clk), .reset(reset), .run(run2), .imem(bus2.master),
        .instr0(instr0_2), .current_state(state_2), .pc(pc_2),
        .retired(retired_2), .halted(halted_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int step_idx   = 0;

    typedef struct {
        logic        run;
        logic        ack;
        logic [31:0] rdata;
        logic [3:0]  st;
        logic        req;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
        logic        hlt;
    } step_t;

    step_t       q[$];
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ret;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_idx, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // One expected cycle: outputs follow from the instruction-level model.
    task automatic push(input logic r, input logic a, input logic [31:0] d, input logic [3:0] st);
        step_t s;
        s.run   = r;
        s.ack   = a;
        s.rdata = d;
        s.st    = st;
        s.req   = (st == S_FETCH) || (st == S_WAIT);
        s.addr  = s.req ? m_pc : 16'd0;
        s.pc    = m_pc;
        s.instr = m_instr;
        s.ret   = m_ret;
        s.hlt   = (st == S_HALT) || (st == S_STOP);
        q.push_back(s);
    endtask

    // Idle in HALT for n cycles (stray acks allowed), then raise run.
    task automatic gen_halt(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rbit(), $urandom, S_HALT);
        push(1'b1, rbit(), $urandom, S_HALT);
    endtask

    // One instruction: FETCH, lat unacked WAIT cycles, acked WAIT, EXEC.
    task automatic gen_instr(input logic [31:0] word, input int lat, input logic run_exec);
        push(rbit(), 1'b0, $urandom, S_FETCH);
        for (int i = 0; i < lat; i++) push(rbit(), 1'b0, $urandom, S_WAIT);
        push(rbit(), 1'b1, word, S_WAIT);
        m_instr = word;
        m_pc    = m_pc + 16'd1;
        push(run_exec, rbit(), $urandom, S_EXEC);
        m_ret   = m_ret + 32'd1;
    endtask

    task automatic gen_stop(input int n);
        for (int i = 0; i < n; i++) push(rbit(), rbit(), $urandom, S_STOP);
    endtask

    task automatic replay();
        foreach (q[k]) begin
            @(posedge clk);
            #1;
            step_idx++;
            check("state",   64'(current_state), 64'(q[k].st));
            check("req",     64'(bus.imem_req),  64'(q[k].req));
            check("addr",    64'(bus.imem_addr), 64'(q[k].addr));
            check("pc",      64'(pc),            64'(q[k].pc));
            check("instr0",  64'(instr0),        64'(q[k].instr));
            check("retired", 64'(retired),       64'(q[k].ret));
            check("halted",  64'(halted),        64'(q[k].hlt));
            run            = q[k].run;
            bus.imem_ack   = q[k].ack;
            bus.imem_rdata = q[k].rdata;
        end
        q.delete();
    endtask

    // Assert reset between clock edges and check outputs before any edge.
    task automatic reset_async();
        #2;
        reset = 1'b1;
        #1;
        check("rst_state",   64'(current_state), 64'(S_HALT));
        check("rst_req",     64'(bus.imem_req),  64'd0);
        check("rst_addr",    64'(bus.imem_addr), 64'd0);
        check("rst_pc",      64'(pc),            64'd0);
        check("rst_instr0",  64'(instr0),        64'd0);
        check("rst_retired", 64'(retired),       64'd0);
        check("rst_halted",  64'(halted),        64'd1);
    endtask

    task automatic release_reset(input logic ack);
        @(posedge clk);
        #3;
        run            = 1'b0;
        bus.imem_ack   = ack;
        bus.imem_rdata = $urandom;
        reset          = 1'b0;
        m_pc    = 16'd0;
        m_instr = 32'd0;
        m_ret   = 32'd0;
    endtask

    initial begin
        logic [31:0] w;
        logic        r;
        reset           = 1'b0;
        run             = 1'b0;
        run2            = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus2.imem_ack   = 1'b0;
        bus2.imem_rdata = 32'd0;

        // Zero-wait program ending in the halt opcode.
        reset_async();
        check("rst2_pc", 64'(pc_2), 64'd15);
        release_reset(1'b0);
        gen_halt(0);
        gen_instr(32'h01000005, 0, 1'b1);
        gen_instr(32'h01040007, 0, 1'b1);
        gen_instr(32'hFF000000, 0, 1'b1);
        gen_stop(4);
        replay();
        check("prog_pc",      64'(pc),      64'd3);
        check("prog_retired", 64'(retired), 64'd3);

        // Slow ack, run dropped mid-fetch, resume, then random traffic.
        reset_async();
        release_reset(1'b0);
        gen_halt(1);
        gen_instr(32'h0A0B0C0D, 5, 1'b0);
        gen_halt(2);
        gen_instr(32'h12345678, 1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (w[31:24] == 8'hFF) w[24] = 1'b0;
            r = ($urandom_range(0, 3) != 0);
            gen_instr(w, $urandom_range(0, 3), r);
            if (!r) gen_halt($urandom_range(0, 2));
        end
        gen_instr(32'hFF00ABCD, $urandom_range(0, 3), 1'b1);
        gen_stop(3);
        replay();

        // Reset pulsed while waiting on memory; later stray acks are ignored.
        reset_async();
        release_reset(1'b0);
        gen_halt(0);
        push(rbit(), 1'b0, $urandom, S_FETCH);
        push(rbit(), 1'b0, $urandom, S_WAIT);
        push(rbit(), 1'b0, $urandom, S_WAIT);
        replay();
        reset_async();
        release_reset(1'b1);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, $urandom, S_HALT);
        replay();

        // Narrow PC wraps from 15 to 0 after one instruction.
        run2 = 1'b1;
        @(posedge clk); #1;
        check("w_state_fetch", 64'(state_2),         64'(S_FETCH));
        check("w_addr",        64'(bus2.imem_addr),  64'd15);
        run2 = 1'b0;
        @(posedge clk); #1;
        check("w_state_wait",  64'(state_2),         64'(S_WAIT));
        bus2.imem_ack   = 1'b1;
        bus2.imem_rdata = 32'h00C0FFEE;
        @(posedge clk); #1;
        bus2.imem_ack = 1'b0;
        check("w_state_exec",  64'(state_2),         64'(S_EXEC));
        check("w_pc_wrap",     64'(pc_2),            64'd0);
        check("w_instr0",      64'(instr0_2),        64'h00C0FFEE);
        @(posedge clk); #1;
        check("w_state_halt",  64'(state_2),         64'(S_HALT));
        check("w_retired",     64'(retired_2),       64'd1);
        check("w_halted",      64'(halted_2),        64'd1);
        check("w_pc_hold",     64'(pc_2),            64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
